// File: rtl/pid_cache_sa.sv
// pid_cache_sa: PID-tagged, set-associative (1 or 2 way) data cache.
// Lines are keyed by {PID, addr}. A read that misses raises pagefault. A
// flush command invalidates every line owned by one PID. Saturating
// counters track read hits and misses.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cmd             00 idle, 01 read, 10 write, 11 flush PID
//   datavalid       command strobe, only sampled while wd=1
//   addr/datain/PID request word address, write data, process ID
//   wd              ready, high only in IDLE
//   dataout         read data, qualified by outvalid
//   outvalid        one-cycle read-hit pulse
//   pagefault       one-cycle read-miss pulse
//   busy            high whenever the FSM is not IDLE
//   hit_cnt         saturating read-hit count
//   miss_cnt        saturating read-miss count
module pid_cache_sa #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 12,
   parameter int PID_W  = 4,
   parameter int SETS   = 16,
   parameter int WAYS   = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        cmd,
   input  logic              datavalid,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] datain,
   input  logic [PID_W-1:0]  PID,
   output logic              wd,
   output logic [DATA_W-1:0] dataout,
   output logic              outvalid,
   output logic              pagefault,
   output logic              busy,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W;

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_RESP, S_FLUSH} state_t;

   state_t              state_q;
   logic [1:0]          cmd_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   din_q;
   logic [PID_W-1:0]    pid_q;
   logic [IDX_W-1:0]    fidx_q;
   logic [DATA_W-1:0]   dout_q;
   logic                ov_q, pf_q;
   logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q, hit_cnt_d, miss_cnt_d;

   logic [SETS-1:0]     valid_q [WAYS];
   logic [PID_W-1:0]    ptag_q  [WAYS][SETS];
   logic [TAG_W-1:0]    atag_q  [WAYS][SETS];
   logic [DATA_W-1:0]   data_q  [WAYS][SETS];
   logic [SETS-1:0]     lru_q;            // per set: 1 = way 1 is the victim

   logic [IDX_W-1:0]    idx;
   logic [TAG_W-1:0]    tag;
   logic [WAYS-1:0]     hit_v, vict_v, way_v;
   logic [DATA_W-1:0]   rdata;

   assign idx = addr_q[IDX_W-1:0];
   assign tag = addr_q[ADDR_W-1:IDX_W];

   // Tag compare; at most one way can match, so OR-ing the data is a mux.
   always_comb begin
      hit_v = '0;
      rdata = '0;
      for (int w = 0; w < WAYS; w++) begin
         hit_v[w] = valid_q[w][idx] && (ptag_q[w][idx] == pid_q) &&
                    (atag_q[w][idx] == tag);
         if (hit_v[w]) rdata = rdata | data_q[w][idx];
      end
   end

   // Victim choice: first invalid way, otherwise the LRU pointer.
   generate
      if (WAYS == 1) begin : g_dm
         assign vict_v = 1'b1;
      end else begin : g_2w
         assign vict_v = !valid_q[0][idx] ? 2'b01 :
                         !valid_q[1][idx] ? 2'b10 :
                         (lru_q[idx] ? 2'b10 : 2'b01);
      end
   endgenerate

   assign way_v      = (|hit_v) ? hit_v : vict_v;
   assign hit_cnt_d  = (&hit_cnt_q)  ? hit_cnt_q  : hit_cnt_q  + CNT_W'(1);
   assign miss_cnt_d = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         cmd_q      <= '0;
         addr_q     <= '0;
         din_q      <= '0;
         pid_q      <= '0;
         fidx_q     <= '0;
         dout_q     <= '0;
         ov_q       <= 1'b0;
         pf_q       <= 1'b0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         lru_q      <= '0;
         for (int w = 0; w < WAYS; w++) begin
            valid_q[w] <= '0;
            for (int s = 0; s < SETS; s++) begin
               ptag_q[w][s] <= '0;
               atag_q[w][s] <= '0;
               data_q[w][s] <= '0;
            end
         end
      end else begin
         ov_q <= 1'b0;
         pf_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (datavalid && cmd != 2'b00) begin
                  cmd_q   <= cmd;
                  addr_q  <= addr;
                  din_q   <= datain;
                  pid_q   <= PID;
                  fidx_q  <= '0;
                  state_q <= (cmd == 2'b11) ? S_FLUSH : S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (cmd_q == 2'b10) begin
                  for (int w = 0; w < WAYS; w++) begin
                     if (way_v[w]) begin
                        valid_q[w][idx] <= 1'b1;
                        ptag_q[w][idx]  <= pid_q;
                        atag_q[w][idx]  <= tag;
                        data_q[w][idx]  <= din_q;
                     end
                  end
                  // Point LRU at the way not just touched.
                  if (WAYS == 2) lru_q[idx] <= way_v[0];
                  state_q <= S_IDLE;
               end else begin
                  if (|hit_v) begin
                     ov_q      <= 1'b1;
                     dout_q    <= rdata;
                     hit_cnt_q <= hit_cnt_d;
                     if (WAYS == 2) lru_q[idx] <= hit_v[0];
                  end else begin
                     pf_q       <= 1'b1;
                     dout_q     <= '0;
                     miss_cnt_q <= miss_cnt_d;
                  end
                  state_q <= S_RESP;
               end
            end
            S_RESP: state_q <= S_IDLE;
            S_FLUSH: begin
               for (int w = 0; w < WAYS; w++)
                  if (ptag_q[w][fidx_q] == pid_q) valid_q[w][fidx_q] <= 1'b0;
               if (fidx_q == IDX_W'(SETS - 1)) state_q <= S_IDLE;
               else                            fidx_q  <= fidx_q + IDX_W'(1);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign wd        = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign dataout   = dout_q;
   assign outvalid  = ov_q;
   assign pagefault = pf_q;
   assign hit_cnt   = hit_cnt_q;
   assign miss_cnt  = miss_cnt_q;

endmodule
